// File: rtl/soc_system_hps_response.sv
// FPGA-to-HPS response port: an Avalon-MM slave that presents a software-written
// word on out_port with a valid/ack handshake. Optional interrupt: HPS_RESPONSE_IRQ_EN.
module soc_system_hps_response #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ack
`ifdef HPS_RESPONSE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_ACK_COUNT = 3'd2;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  logic                  wr;
  logic                  wr_word;
  logic                  wr_status;
  logic                  wr_ack_count;
  logic                  accept;
  logic [DATA_WIDTH-1:0] port_next;
  logic [DATA_WIDTH-1:0] read_mux;

  logic       overrun;
  logic       done;
  logic [7:0] ack_count;
  logic       irq_mask;

  assign wr           = chipselect & ~write_n;
  assign wr_status    = wr & (address == ADDR_STATUS);
  assign wr_ack_count = wr & (address == ADDR_ACK_COUNT);
  assign wr_word      = wr & ((address == ADDR_DATA) ||
                              (address == ADDR_OUTSET) ||
                              (address == ADDR_OUTCLEAR));

  // The consumer can only accept a word that is actually being offered.
  assign accept = out_ack & out_valid;

  always_comb begin
    port_next = out_port;
    unique case (address)
      ADDR_DATA:     port_next = writedata;
      ADDR_OUTSET:   port_next = out_port | writedata;
      ADDR_OUTCLEAR: port_next = out_port & ~writedata;
      default:       port_next = out_port;
    endcase
  end

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:      read_mux = out_port;
      ADDR_STATUS:    read_mux = {{(DATA_WIDTH-3){1'b0}}, done, overrun, out_valid};
      ADDR_ACK_COUNT: read_mux = {{(DATA_WIDTH-8){1'b0}}, ack_count};
      ADDR_IRQ_MASK:  read_mux = {{(DATA_WIDTH-1){1'b0}}, irq_mask};
      default:        read_mux = '0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port  <= RESET_VALUE;
      out_valid <= 1'b0;
      readdata  <= '0;
      overrun   <= 1'b0;
      done      <= 1'b0;
      ack_count <= 8'd0;
    end else begin
      readdata <= chipselect ? read_mux : '0;

      if (wr_word) begin
        out_port  <= port_next;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end

      // A new word replacing an unaccepted one is an overrun, unless the old
      // word was accepted on this very edge. Set events beat a software clear.
      if (wr_word && !accept && out_valid) begin
        overrun <= 1'b1;
      end else if (wr_status && writedata[1]) begin
        overrun <= 1'b0;
      end

      if (accept) begin
        done <= 1'b1;
      end else if (wr_status && writedata[2]) begin
        done <= 1'b0;
      end

      ack_count <= (wr_ack_count ? 8'd0 : ack_count) + {7'd0, accept};
    end
  end

`ifdef HPS_RESPONSE_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr && (address == ADDR_IRQ_MASK)) begin
        irq_mask <= writedata[0];
      end
      irq <= irq_mask & done;
    end
  end
`else
  assign irq_mask = 1'b0;
`endif

endmodule

// File: tb/tb_soc_system_hps_response.sv
// Directed self-checking bench for soc_system_hps_response (RESET_VALUE = 32'hA5A5_0000).
// Builds with or without HPS_RESPONSE_IRQ_EN.
module tb_soc_system_hps_response;

  localparam int          DW    = 32;
  localparam logic [31:0] RST_V = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic [DW-1:0] out_port;
  logic          out_valid;
  logic          out_ack;
`ifdef HPS_RESPONSE_IRQ_EN
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_system_hps_response #(
    .DATA_WIDTH (DW),
    .RESET_VALUE(RST_V)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ack   (out_ack)
`ifdef HPS_RESPONSE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Bus helpers: inputs change on the falling edge, outputs are sampled on the falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  task automatic write_with_ack(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d; out_ack = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; out_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; out_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_port !== RST_V) begin
      errors++; $display("FAIL reset_port: got %h expected %h", out_port, RST_V);
    end
    checks++;
    if (readdata !== 32'd0) begin
      errors++; $display("FAIL reset_readdata: got %h expected 0", readdata);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i == 0) ? RST_V : 32'd0;
      bus_read(3'(i), rd);
      checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL reset_read_addr%0d: got %h expected %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    bus_write(3'd0, 32'h1234_5678);
    checks++;
    if (out_port !== 32'h1234_5678 || out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_load: got port=%h valid=%b expected 12345678/1", out_port, out_valid);
    end
    pulse_ack();
    checks++;
    if (out_valid !== 1'b0 || out_port !== 32'h1234_5678) begin
      errors++; $display("FAIL basic_ack: got port=%h valid=%b expected 12345678/0", out_port, out_valid);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h4) begin
      errors++; $display("FAIL basic_status: got %h expected 4", rd);
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL basic_ack_count: got %h expected 1", rd);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    bus_write(3'd0, 32'h1);
    bus_write(3'd0, 32'h2);
    checks++;
    if (out_port !== 32'h2) begin
      errors++; $display("FAIL overrun_port: got %h expected 2", out_port);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h7) begin
      errors++; $display("FAIL overrun_status: got %h expected 7", rd);
    end
    bus_write(3'd1, 32'h2);
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h5) begin
      errors++; $display("FAIL overrun_clear: got %h expected 5", rd);
    end
    pulse_ack();
    pulse_ack();  // out_valid already 0: must not count
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd2) begin
      errors++; $display("FAIL idle_ack_ignored: got %h expected 2", rd);
    end
    bus_write(3'd0, 32'h3);
    @(negedge clk);
    out_ack = 1'b1;
    repeat (3) @(negedge clk);
    out_ack = 1'b0;
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd3) begin
      errors++; $display("FAIL held_ack_counts_once: got %h expected 3", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bus_write(3'd1, 32'h6);
    bus_write(3'd0, 32'hAA);
    write_with_ack(3'd0, 32'hBB);
    checks++;
    if (out_valid !== 1'b1 || out_port !== 32'hBB) begin
      errors++; $display("FAIL b2b_load: got port=%h valid=%b expected bb/1", out_port, out_valid);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h5) begin
      errors++; $display("FAIL b2b_no_overrun: got status %h expected 5", rd);
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd4) begin
      errors++; $display("FAIL b2b_ack_count: got %h expected 4", rd);
    end
    // done clear in the same cycle as an ack: the set wins
    write_with_ack(3'd1, 32'h4);
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h4) begin
      errors++; $display("FAIL clear_vs_set_done: got status %h expected 4", rd);
    end
    bus_write(3'd0, 32'hCC);
    write_with_ack(3'd2, 32'h0);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++; $display("FAIL count_clear_vs_ack: got %h expected 1", rd);
    end
  endtask

  task automatic test_outset_outclear();
    logic [31:0] rd;
    bus_write(3'd0, 32'hF0F0_F0F0);
    bus_write(3'd4, 32'h0000_000F);
    checks++;
    if (out_port !== 32'hF0F0_F0FF || out_valid !== 1'b1) begin
      errors++; $display("FAIL outset: got port=%h valid=%b expected f0f0f0ff/1", out_port, out_valid);
    end
    bus_write(3'd5, 32'hF000_0000);
    checks++;
    if (out_port !== 32'h00F0_F0FF || out_valid !== 1'b1) begin
      errors++; $display("FAIL outclear: got port=%h valid=%b expected 00f0f0ff/1", out_port, out_valid);
    end
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL outset_read: got %h expected 0", rd);
    end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL outclear_read: got %h expected 0", rd);
    end
    pulse_ack();
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    bus_write(3'd2, 32'hFFFF_FFFF);
    for (int i = 0; i < 256; i++) begin
      bus_write(3'd0, 32'(i));
      pulse_ack();
      if (i == 254) begin
        bus_read(3'd2, rd);
        checks++;
        if (rd !== 32'd255) begin
          errors++; $display("FAIL ack_count_255: got %h expected ff", rd);
        end
      end
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL ack_count_wrap: got %h expected 0", rd);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
`ifdef HPS_RESPONSE_IRQ_EN
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL irq_mask_read: got %h expected 1", rd);
    end
    bus_write(3'd1, 32'h6);
    bus_write(3'd0, 32'h5);
    pulse_ack();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_registered: got %b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_set: got %b expected 1", irq);
    end
    bus_write(3'd1, 32'h4);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_clear: got %b expected 0", irq);
    end
`else
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL irq_mask_absent: got %h expected 0", rd);
    end
`endif
  endtask

  task automatic test_reset_mid_handshake();
    logic [31:0] rd;
    bus_write(3'd0, 32'h77);
    @(negedge clk);
    reset_n = 1'b0; out_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_port !== RST_V) begin
      errors++; $display("FAIL reset_mid: got port=%h valid=%b expected %h/0", out_port, out_valid, RST_V);
    end
    reset_n = 1'b1; out_ack = 1'b0;
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL reset_mid_count: got %h expected 0", rd);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL reset_mid_status: got %h expected 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_outset_outclear();
    test_wrap();
    test_irq();
    test_reset_mid_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
